// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide, with sign fix-up and a pipeline stall while running.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned AW    = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_a_q, neg_b_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  // Request decode, evaluated directly on the inputs while IDLE
  logic            is_div, sign_a, sign_b, neg_a_in, neg_b_in;
  logic            div_zero, ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    is_div   = func3[2];
    sign_a   = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
    sign_b   = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    neg_a_in = sign_a & op_a[XLEN-1];
    neg_b_in = sign_b & op_b[XLEN-1];
    mag_a    = neg_a_in ? -op_a : op_a;
    mag_b    = neg_b_in ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    ovf      = ((func3 == 3'b100) || (func3 == 3'b110)) && (op_a == INT_MIN) && (op_b == '1);
    special  = div_zero || ovf;
    if (div_zero) special_res = func3[1] ? op_a : '1;
    else          special_res = func3[1] ? '0 : INT_MIN;
    accept   = (state_q == IDLE) && start && !flush;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Output decode: stall is combinational, busy/valid are registered from state_d
  always_comb begin
    stall   = !flush && ((start && (state_q == IDLE)) || (state_q == CALC) || (state_q == FIX));
    busy_d  = (state_d == CALC) || (state_d == FIX);
    valid_d = (state_d == DONE);
  end

  // One iteration of shift-add multiply and restoring divide, plus sign fix-up
  logic [XLEN:0]   mul_sum, div_trial;
  logic [AW-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0] quot, rem, fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[AW-1:XLEN-1] - {1'b0, opnd_q};
    if (!div_trial[XLEN]) div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                  div_next = {acc_q[AW-2:0], 1'b0};
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = neg_a_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    if (func3_q[2])                fix_res = func3_q[1] ? rem : quot;
    else if (func3_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                           fix_res = prod[AW-1:XLEN];
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      func3_q  <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      if (accept) begin
        func3_q <= func3;
        rd_q    <= rd_in;
        neg_a_q <= neg_a_in;
        neg_b_q <= neg_b_in;
        opnd_q  <= is_div ? mag_b : mag_a;
        acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
        cnt_q   <= '0;
        if (special && state_d == DONE) begin
          result_q <= special_res;
          rd_out_q <= rd_in;
        end
      end
      if (state_q == CALC) begin
        acc_q <= func3_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == FIX && state_d == DONE) begin
        result_q <= fix_res;
        rd_out_q <= rd_q;
      end
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = result_q;
  assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected results,
// a negedge monitor pops and checks value, rd and completion cycle.
module tb_muldiv_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n, start, flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      rd_in;
  logic            stall, busy, result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
    .stall(stall), .busy(busy), .result_valid(result_valid),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every result_valid must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: result 0x%08h rd %0d with empty scoreboard (cycle %0d)",
                 result, rd_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one op at the current cycle T and wait for its completion
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
    exp_t e;
    int   stall_cnt;
    bit   seen;
    func3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    e.res = exp_res; e.rd = rd; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    stall_cnt = stall ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (i == 0 && lat > 1) chk("busy_calc", 32'(busy), 32'd1);
      if (result_valid) begin
        seen = 1'b1;
        chk("stall_in_done", 32'(stall), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd0);
      end else if (stall) begin
        stall_cnt++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: no result_valid for func3 %0d got 0 expected 1", f3);
    end
    chk("stall_cycles", 32'(stall_cnt), 32'(lat));
    @(posedge clk); #1;
  endtask

  logic [2:0]  v_f3  [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [31:0] v_a   [14] = '{32'd7, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9};
  logic [31:0] v_b   [14] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [31:0] v_exp [14] = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hC0000000,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                              32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
  int          v_lat [14] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 1};

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    func3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", 32'(rd_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op(v_f3[i], v_a[i], v_b[i], 5'(i + 1), v_exp[i], v_lat[i]);

    // Flush at T+10 of a MUL, restart at T+11
    func3 = 3'd0; op_a = 32'd3; op_b = 32'd9; rd_in = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("stall_during_flush", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("busy_after_flush", 32'(busy), 32'd0);
    chk("stall_after_flush", 32'(stall), 32'd0);
    run_op(3'd0, 32'd6, 32'd7, 5'd21, 32'd42, 34);

    // Async reset mid-DIV
    func3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_valid", 32'(result_valid), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_rd", 32'(rd_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd7, 32'd1000, 32'd3, 5'd23, 32'd1, 34);

    repeat (40) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for RV32M multiply/divide operations in the execute stage.
- Execute asserts `start` when the decoded op is an M-extension op (op=0110011, func7=0000001).
- The sequencer runs a radix-2 iterative shift-add multiply or restoring divide, and holds `stall` high so decode/execute keep their outputs.
- On completion it returns the result and destination register for the write-back path.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request from execute; sampled only in IDLE
func3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (forwarded)
op_b  input  XLEN  rs2 value (forwarded)
rd_in  input  5  destination register of the request
flush  input  1  branch/jump flush; aborts any in-flight op
stall  output  1  pipeline hold request to fetch/decode/execute
busy  output  1  high in CALC or FIX
result_valid  output  1  one-cycle pulse; result/rd_out valid
result  output  XLEN  operation result
rd_out  output  5  destination register of the completed op

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, result_valid, stall=0; result, rd_out, internal registers all zero. Reset mid-operation discards the op; no result_valid follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start (cycle T):
  - Latch func3, rd_in, and operand magnitudes plus sign flags.
  - Signedness per func3:
    - MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - DIV and REM: both operands signed.
    - All others unsigned.
  - Special cases go IDLE->DONE, with result_valid at T+1:
    - divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
    - signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Otherwise go to CALC and clear the 6-bit iteration counter.
- CALC: one iteration per cycle for exactly XLEN cycles (T+1..T+XLEN).
  - Multiply: 2*XLEN-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring shift-subtract on a 2*XLEN-bit remainder/quotient register.
  - On counter==XLEN-1, go to FIX.
- FIX (T+XLEN+1): apply sign correction by two's-complement negation.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Then select the output: MUL -> low XLEN bits; MULH* -> high XLEN bits.
- DONE (T+XLEN+2): result_valid=1, result/rd_out registered; next state IDLE. Latency: XLEN+2 cycles normal, 1 cycle special case.
- result/rd_out hold their last value until the next DONE; result_valid is high only in DONE.
- stall = (start && state==IDLE) || state==CALC || state==FIX. It is combinational and low in DONE, so the pipeline advances on the result cycle.
- busy = state==CALC || state==FIX, registered.
- start while not IDLE: ignored. start in DONE is not accepted; it is re-sampled next cycle in IDLE.
- flush: from any state, next state IDLE; a pending DONE is suppressed (result_valid=0). flush has priority over start in the same cycle; stall=0 while flush is high.
- All arithmetic is modulo 2^XLEN. The counter must not wrap: exactly XLEN iterations.

Test Plan:
- MUL with op_a=7, op_b=0xFFFFFFFD, start at T -> stall high T..T+33, result_valid at T+34, result=0xFFFFFFEB, rd_out=rd_in.
- MULH, MULHU, MULHSU with op_a=op_b=0x80000000 -> results 0x40000000, 0x40000000, 0xC0000000 respectively.
- DIV with op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU with op_b=0 (op_a=5) -> result_valid at T+1 with 0xFFFFFFFF; REMU -> 5. DIV with op_a=0x80000000, op_b=0xFFFFFFFF -> 0x80000000 at T+1; REM -> 0.
- Flush at T+10 during MUL -> busy and stall low at T+11, no result_valid ever. A new start at T+11 completes normally at T+45.
- rst_n low at T+5 mid-DIV -> all outputs 0 immediately. After release, start is accepted and result_valid does not fire for the aborted op.
